// File: rtl/psx_pkg.sv
// Shared types and constants for the PSX controller poll scheduler.
package psx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATT,
        ST_SEND,
        ST_XFER,
        ST_ACKW,
        ST_END,
        ST_GAP
    } state_t;

    localparam logic [7:0] PSX_CMD_START     = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL      = 8'h42;
    localparam logic [7:0] PSX_CMD_IDLE      = 8'h00;
    localparam logic [3:0] PSX_ID_DIGITAL_HI = 4'h4;
    localparam int         POLL_LEN          = 5;

    // Command byte sent at each position of the 5-byte digital poll.
    function automatic logic [7:0] poll_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    poll_cmd = PSX_CMD_START;
            3'd1:    poll_cmd = PSX_CMD_POLL;
            default: poll_cmd = PSX_CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/psx_poll_scheduler_if.sv
// Byte-engine handshake, controller ack and per-port attention lines.
interface psx_poll_scheduler_if #(
    parameter int NUM_PORTS = 2
);
    logic                 eng_start;
    logic [7:0]           eng_tx_byte;
    logic                 eng_done;
    logic [7:0]           eng_rx_byte;
    logic                 ack_n;
    logic [NUM_PORTS-1:0] att_n;

    modport master (
        output eng_start, eng_tx_byte, att_n,
        input  eng_done, eng_rx_byte, ack_n
    );

    modport slave (
        input  eng_start, eng_tx_byte, att_n,
        output eng_done, eng_rx_byte, ack_n
    );
endinterface

// File: rtl/psx_poll_scheduler_frame_timer.sv
// Free-running frame counter; tick is high during the last count before wrap.
module psx_frame_timer #(
    parameter int FRAME_CYCLES = 117
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(FRAME_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/psx_poll_scheduler.sv
// Walks every controller port once per frame over a shared serial byte engine,
// issuing the digital poll and latching each port's button word.
module psx_poll_scheduler
    import psx_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int FRAME_CYCLES = 117,
    parameter int ATT_SETUP    = 2,
    parameter int ACK_TIMEOUT  = 10,
    parameter int GAP_CYCLES   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    psx_poll_scheduler_if.master    eng,
    output logic [16*NUM_PORTS-1:0] pad_buttons,
    output logic [NUM_PORTS-1:0]    pad_connected,
    output logic                    frame_done,
    output logic [7:0]              overrun_cnt
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W  = 8;

    state_t             state, state_nxt;
    logic [PORT_W-1:0]  port;
    logic [2:0]         byte_idx;
    logic [CNT_W-1:0]   cnt;
    logic               failed;
    logic               stop_req;
    logic [3:0]         id_hi;
    logic [7:0]         btn_lo, btn_hi;
    logic               tick;
    logic               active, last_port, stop, poll_ok;

    psx_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign active    = (state == ST_ATT) || (state == ST_SEND) ||
                       (state == ST_XFER) || (state == ST_ACKW);
    assign last_port = (port == PORT_W'(NUM_PORTS - 1));
    // A disable seen at any point of the round ends it after the current port.
    assign stop      = stop_req || !enable;
    assign poll_ok   = !failed && (id_hi == PSX_ID_DIGITAL_HI);

    assign eng.eng_tx_byte = poll_cmd(byte_idx);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_att
        assign eng.att_n[p] = !(active && (port == PORT_W'(p)));
    end

    always_comb begin
        state_nxt     = state;
        eng.eng_start = 1'b0;
        frame_done    = 1'b0;
        case (state)
            ST_IDLE: if (tick && enable) state_nxt = ST_ATT;
            ST_ATT:  if (cnt == CNT_W'(ATT_SETUP - 1)) state_nxt = ST_SEND;
            ST_SEND: begin
                eng.eng_start = 1'b1;
                state_nxt     = ST_XFER;
            end
            ST_XFER: if (eng.eng_done)
                state_nxt = (byte_idx == 3'(POLL_LEN - 1)) ? ST_END : ST_ACKW;
            // Ack is checked before expiry so a last-cycle ack still succeeds.
            ST_ACKW: begin
                if (!eng.ack_n)                              state_nxt = ST_SEND;
                else if (cnt == CNT_W'(ACK_TIMEOUT - 1))     state_nxt = ST_END;
            end
            ST_END:  state_nxt = ST_GAP;
            ST_GAP:  if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                if (stop)           state_nxt = ST_IDLE;
                else if (last_port) begin
                    state_nxt  = ST_IDLE;
                    frame_done = 1'b1;
                end else            state_nxt = ST_ATT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            port          <= '0;
            byte_idx      <= '0;
            cnt           <= '0;
            failed        <= 1'b0;
            stop_req      <= 1'b0;
            id_hi         <= '0;
            btn_lo        <= '0;
            btn_hi        <= '0;
            pad_buttons   <= '1;
            pad_connected <= '0;
            overrun_cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;

            if (tick && state != ST_IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 1'b1;

            if (state == ST_IDLE) stop_req <= 1'b0;
            else if (!enable)     stop_req <= 1'b1;

            case (state)
                ST_IDLE: if (state_nxt == ST_ATT) port <= '0;
                ST_ATT: begin
                    byte_idx <= '0;
                    failed   <= 1'b0;
                    id_hi    <= '0;
                end
                ST_XFER: if (eng.eng_done) begin
                    case (byte_idx)
                        3'd1:    id_hi  <= eng.eng_rx_byte[7:4];
                        3'd3:    btn_lo <= eng.eng_rx_byte;
                        3'd4:    btn_hi <= eng.eng_rx_byte;
                        default: ;
                    endcase
                end
                ST_ACKW: begin
                    if (!eng.ack_n)                          byte_idx <= byte_idx + 3'd1;
                    else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) failed   <= 1'b1;
                end
                ST_END: begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (port == PORT_W'(p)) begin
                            pad_buttons[16*p +: 16] <= poll_ok ? {btn_hi, btn_lo} : 16'hFFFF;
                            pad_connected[p]        <= poll_ok;
                        end
                    end
                end
                ST_GAP: if (state_nxt == ST_ATT) port <= port + PORT_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_psx_poll_scheduler.sv
// Directed bench: behavioural byte engine / controllers plus linear checks.
module tb_psx_poll_scheduler;
    localparam int NP = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic [16*NP-1:0] pad_buttons;
    logic [NP-1:0]   pad_connected;
    logic            frame_done;
    logic [7:0]      overrun_cnt;

    psx_poll_scheduler_if #(.NUM_PORTS(NP)) bus ();

    psx_poll_scheduler #(
        .NUM_PORTS(NP), .FRAME_CYCLES(117), .ATT_SETUP(2),
        .ACK_TIMEOUT(10), .GAP_CYCLES(3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .eng           (bus.master),
        .pad_buttons   (pad_buttons),
        .pad_connected (pad_connected),
        .frame_done    (frame_done),
        .overrun_cnt   (overrun_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_tbl [NP][5];
    bit         ack_en [NP];
    bit         xfer_ack [NP];
    int         ack_dly = 0;
    int         stall_idx = -1;
    logic [7:0] tx_log [64];
    int         log_n = 0;
    int         bad_att = 0, p1_low = 0, fd_cnt = 0;
    int         checks = 0, errors = 0;

    always @(negedge clk) begin
        if (bus.att_n == 2'b00) bad_att++;
        if (!bus.att_n[1])      p1_low++;
        if (frame_done)         fd_cnt++;
    end

    // Engine + controller model: done one cycle after start, ack ack_dly cycles into ACKW.
    initial begin
        int p, idx;
        bus.eng_done = 1'b0; bus.ack_n = 1'b1; bus.eng_rx_byte = 8'h00;
        idx = 0; p = 0;
        forever begin
            @(posedge clk); #1;
            if (bus.att_n == 2'b11) idx = 0;
            while (bus.eng_start) begin
                p = bus.att_n[0] ? 1 : 0;
                if (log_n < 64) tx_log[log_n] = bus.eng_tx_byte;
                log_n++;
                @(posedge clk); #1;
                if (idx == stall_idx) break;
                bus.eng_done = 1'b1;
                bus.eng_rx_byte = rx_tbl[p][idx];
                if (xfer_ack[p]) bus.ack_n = 1'b0;
                @(posedge clk); #1;
                bus.eng_done = 1'b0; bus.ack_n = 1'b1;
                if (idx < 4 && ack_en[p]) begin
                    repeat (ack_dly) begin @(posedge clk); #1; end
                    bus.ack_n = 1'b0;
                    @(posedge clk); #1;
                    bus.ack_n = 1'b1;
                end
                idx++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_att(input logic [1:0] val, input string tag);
        int n = 0;
        while (bus.att_n !== val && n < 400) begin @(negedge clk); n++; end
        chk(tag, 32'(bus.att_n), 32'(val));
    endtask

    task automatic wait_fd(input int target, input string tag);
        int n = 0;
        while (fd_cnt < target && n < 400) begin @(negedge clk); n++; end
        chk(tag, 32'(fd_cnt), 32'(target));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.eng_done && n < 100) begin @(negedge clk); n++; end
        chk(tag, 32'(bus.eng_done), 32'd1);
    endtask

    initial begin
        int n, base, p1base, fdbase, seq_bad;
        logic [7:0] exp_seq [5];
        exp_seq = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
        rx_tbl[0] = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFF};
        rx_tbl[1] = '{8'hFF, 8'h41, 8'h5A, 8'h7F, 8'hBF};
        ack_en = '{1'b1, 1'b1};
        xfer_ack = '{1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_att_n", 32'(bus.att_n), 32'h3);
        chk("rst_eng_start", 32'(bus.eng_start), 32'h0);
        chk("rst_tx_byte", 32'(bus.eng_tx_byte), 32'h01);
        chk("rst_pad_buttons", pad_buttons, 32'hFFFF_FFFF);
        chk("rst_pad_connected", 32'(pad_connected), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_overrun", 32'(overrun_cnt), 32'h0);
        rst_n = 1'b1; enable = 1'b1;

        // Both ports answer normally
        wait_att(2'b10, "t1_att0");
        n = 0;
        while (!bus.eng_start && n < 20) begin @(negedge clk); n++; end
        chk("t1_att_to_start", 32'(n), 32'd2);
        wait_fd(1, "t1_frame_done");
        repeat (5) @(negedge clk);
        chk("t1_single_fd", 32'(fd_cnt), 32'd1);
        chk("t1_pad_buttons", pad_buttons, 32'hBF7F_FFFE);
        chk("t1_pad_connected", 32'(pad_connected), 32'h3);
        chk("t1_tx_count", 32'(log_n), 32'd10);
        seq_bad = 0;
        for (int i = 0; i < 10; i++) if (tx_log[i] !== exp_seq[i % 5]) seq_bad++;
        chk("t1_tx_sequence", 32'(seq_bad), 32'd0);

        // Port1 never acks
        ack_en[1] = 1'b0; base = log_n;
        wait_att(2'b01, "t2_att1");
        wait_done("t2_done");
        n = 0;
        while (!bus.att_n[1] && n < 40) begin @(negedge clk); n++; end
        chk("t2_timeout_len", 32'(n), 32'd11);
        wait_fd(2, "t2_frame_done");
        chk("t2_pad_connected", 32'(pad_connected), 32'h1);
        chk("t2_pad_buttons", pad_buttons, 32'hFFFF_FFFE);
        chk("t2_tx_count", 32'(log_n - base), 32'd6);

        // Port0 reports a non-digital ID
        ack_en[1] = 1'b1; rx_tbl[0][1] = 8'h73;
        wait_fd(3, "t3_frame_done");
        chk("t3_pad_connected", 32'(pad_connected), 32'h2);
        chk("t3_pad_buttons", pad_buttons, 32'hBF7F_FFFF);

        // Ack on the final cycle of the window counts
        rx_tbl[0][1] = 8'h41; ack_dly = 9;
        wait_fd(4, "t4_frame_done");
        chk("t4_pad_connected", 32'(pad_connected), 32'h3);
        chk("t4_pad_buttons", pad_buttons, 32'hBF7F_FFFE);

        // Ack one cycle too late
        ack_dly = 10;
        wait_fd(5, "t5_frame_done");
        chk("t5_pad_connected", 32'(pad_connected), 32'h0);
        chk("t5_pad_buttons", pad_buttons, 32'hFFFF_FFFF);

        // Ack only during XFER must be ignored
        ack_dly = 0; ack_en[0] = 1'b0; xfer_ack[0] = 1'b1;
        wait_fd(6, "t6_frame_done");
        chk("t6_pad_connected", 32'(pad_connected), 32'h2);
        chk("t6_pad_buttons", pad_buttons, 32'hBF7F_FFFF);
        ack_en[0] = 1'b1; xfer_ack[0] = 1'b0;
        chk("t6_no_overrun", 32'(overrun_cnt), 32'h0);

        // Enable dropped during port0 ACKW
        ack_dly = 3; base = log_n; p1base = p1_low; fdbase = fd_cnt;
        wait_att(2'b10, "t7_att0");
        wait_done("t7_done");
        @(negedge clk);
        enable = 1'b0;
        wait_att(2'b11, "t7_port0_release");
        repeat (300) @(negedge clk);
        chk("t7_port1_untouched", 32'(p1_low - p1base), 32'd0);
        chk("t7_no_frame_done", 32'(fd_cnt - fdbase), 32'd0);
        chk("t7_pad_connected", 32'(pad_connected), 32'h3);
        chk("t7_pad_buttons", pad_buttons, 32'hBF7F_FFFE);
        chk("t7_tx_count", 32'(log_n - base), 32'd5);
        chk("t7_att_high", 32'(bus.att_n), 32'h3);

        // Async reset while byte 2 is in flight
        enable = 1'b1; stall_idx = 2; base = log_n;
        wait_att(2'b10, "t8_att0");
        n = 0;
        while (log_n < base + 3 && n < 100) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("t8_stalled_att", 32'(bus.att_n), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("t8_rst_att_async", 32'(bus.att_n), 32'h3);
        chk("t8_rst_eng_start", 32'(bus.eng_start), 32'h0);
        chk("t8_rst_pad_connected", 32'(pad_connected), 32'h0);
        chk("t8_rst_pad_buttons", pad_buttons, 32'hFFFF_FFFF);
        @(negedge clk);
        stall_idx = -1; rst_n = 1'b1; fdbase = fd_cnt; base = log_n;
        n = 0;
        while (bus.att_n === 2'b11 && n < 400) begin @(negedge clk); n++; end
        chk("t8_restart_port0", 32'(bus.att_n), 32'h2);
        wait_fd(fdbase + 1, "t8_frame_done");
        chk("t8_pad_connected", 32'(pad_connected), 32'h3);
        chk("t8_tx_count", 32'(log_n - base), 32'd10);

        // Engine hangs: every later tick is an overrun
        stall_idx = 0;
        wait_att(2'b10, "t9_att0");
        repeat (401) @(negedge clk);
        chk("t9_overrun_3", 32'(overrun_cnt), 32'd3);
        repeat (117 * 260) @(negedge clk);
        chk("t9_overrun_sat", 32'(overrun_cnt), 32'd255);
        chk("att_never_both_low", 32'(bad_att), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/psx_poll_scheduler.md
Name: psx_poll_scheduler

Overview:
- Sequences polling transactions on one shared PSX serial byte engine across NUM_PORTS controller ports.
- Per frame, visits each port in turn: drops that port's att_n, pushes the 5-byte digital poll (0x01 0x42 0x00 0x00 0x00), supervises the controller ack after each byte, and latches the button word.
- Sits between the frame timer/host logic and the bit-level clock/cmd/data engine.

Parameters:
- NUM_PORTS, 2, number of controller ports sharing the engine (1..4).
- FRAME_CYCLES, 117, clk cycles between poll rounds (~60 Hz at 7 kHz).
- ATT_SETUP, 2, clk cycles from att_n low to the first byte start.
- ACK_TIMEOUT, 10, max clk cycles after eng_done to wait for an ack pulse.
- GAP_CYCLES, 3, clk cycles with all att_n high between ports.

Ports:
- clk  in  1  system clock (shared 7 kHz PSX domain).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  polling enabled.
- eng_start  out  1  one-cycle pulse; the engine begins shifting eng_tx_byte.
- eng_tx_byte  out  8  command byte; held stable from eng_start until eng_done.
- eng_done  in  1  one-cycle pulse; byte exchange finished, eng_rx_byte valid.
- eng_rx_byte  in  8  byte received from the controller.
- ack_n  in  1  controller ack, active low, already synchronised.
- att_n  out  NUM_PORTS  per-port attention, active low, at most one low.
- pad_buttons  out  16*NUM_PORTS  latched buttons, port p at [16p+15:16p], active-low bits as received (byte4 low, byte5 high).
- pad_connected  out  NUM_PORTS  last poll of port completed with valid ID.
- frame_done  out  1  one-cycle pulse after the last port of a round.
- overrun_cnt  out  8  saturating count of frame ticks dropped while busy.

Behaviour:
- Reset values: att_n all 1, eng_start 0, eng_tx_byte 0x01, pad_buttons all 1 (0xFFFF per port), pad_connected 0, frame_done 0, overrun_cnt 0, state IDLE, frame counter 0.
- Frame counter: free-runs 0..FRAME_CYCLES-1 regardless of enable. Tick is generated at wrap.
- States:
  - IDLE: on tick with enable=1, set port=0 and go to ATT.
  - ATT: drop att_n[port], wait ATT_SETUP cycles, set byte_idx=0, go to SEND.
  - SEND: pulse eng_start with eng_tx_byte = cmd[byte_idx], go to XFER.
  - XFER: wait for eng_done. Capture rx: idx1 = ID, idx3 = low buttons, idx4 = high buttons. If byte_idx=4 go to END, else go to ACKW.
  - ACKW: on ack_n low, byte_idx+1 and go to SEND. If ACK_TIMEOUT cycles elapse first, set the port as failed and go to END.
  - END: raise att_n[port]. If success (no timeout, ID[7:4]==4'h4), update pad_buttons[port] and set pad_connected[port]=1. Otherwise pad_connected[port]=0 and pad_buttons[port]=0xFFFF. Go to GAP.
  - GAP: wait GAP_CYCLES. If port==NUM_PORTS-1, pulse frame_done and go to IDLE; else port+1 and go to ATT.
- Ack arriving during XFER is ignored; only ack in ACKW counts. An ack on the same cycle as timeout expiry counts as success.
- Byte-to-rx index mapping: rx of byte n is captured on its eng_done.
- Tick while not IDLE: no new round; overrun_cnt+1, saturating at 255.
- enable drop mid-round: current port completes through END/GAP, then return to IDLE without visiting remaining ports; frame_done not pulsed.
- Async reset mid-transaction: att_n all high immediately, engine handshake abandoned, all outputs to reset values.
- Latency: att_n low to first eng_start = ATT_SETUP cycles.

Decomposition:
- Package psx_pkg: state enum, poll command byte constants (PSX_CMD_START=0x01, PSX_CMD_POLL=0x42, PSX_CMD_IDLE=0x00), PSX_ID_DIGITAL_HI=4'h4, POLL_LEN=5.
- One sub-module natural: psx_frame_timer, the free-running FRAME_CYCLES counter emitting the tick.

Test Plan:
- NUM_PORTS=2, both ports model ack after each byte, port0 ID=0x41 buttons 0xFE,0xFF -> eng_tx_byte sequence 01,42,00,00,00 per port; pad_buttons[15:0]=0xFFFE; pad_connected=2'b11; one frame_done; att_n never 2'b00.
- Port1 never acks -> after byte 0, ACK_TIMEOUT cycles then att_n[1] high; pad_connected[1]=0; pad_buttons[31:16]=0xFFFF; port0 unaffected.
- Port0 returns ID=0x73 -> pad_connected[0]=0, buttons reset to 0xFFFF.
- FRAME_CYCLES=20 with a slow engine (round >20 cycles) -> overrun_cnt increments once per skipped tick, saturates at 255.
- rst_n low during XFER of byte 2 -> att_n=all 1 same cycle; after release, state IDLE and the next tick starts a clean round at port 0.
- enable deasserted during port0 ACKW -> port0 finishes, att_n stays high afterwards, port1 not polled, no frame_done.
